// File: rtl/data_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared definitions for the data-memory responder and its byte-lane RAM:
//   the FSM state encoding, byte-lane index constants and wait-state limits.
// ---------------------------------------------------------------------------
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  // Byte lanes of a 32-bit data word; lane n covers bits [8n+7:8n].
  localparam int LANE_MSB  = 3;
  localparam int LANE_LSB  = 0;
  localparam int NUM_LANES = LANE_MSB - LANE_LSB + 1;
  localparam int LANE_W    = 8;

  // Wait-state counter must hold WAIT_STATES_MAX.
  localparam int WAIT_STATES_MAX = 15;
  localparam int CNT_W           = 4;

endpackage : data_mem_responder_pkg

// File: rtl/dmem_bytelane_ram.sv
// ---------------------------------------------------------------------------
// dmem_bytelane_ram
//   2**ADDR_WIDTH x 32 single-port RAM with independent byte write enables
//   and a registered, read-before-write read port.  Each lane is its own
//   8-bit array so the tools map it onto byte-enabled block RAM.
//
//   clk_i    clock
//   addr_i   word address
//   re_i     read enable: load rdata_o with the word before this write
//   we_i     per-lane write enables ([3] = bits 31:24 ... [0] = bits 7:0)
//   wdata_i  write data
//   rdata_o  registered read data (holds between reads)
// ---------------------------------------------------------------------------
module dmem_bytelane_ram
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  re_i,
  input  logic [NUM_LANES-1:0]  we_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  genvar gi;
  generate
    for (gi = LANE_LSB; gi <= LANE_MSB; gi++) begin : g_lane
      logic [LANE_W-1:0] mem [DEPTH];
      logic [LANE_W-1:0] rdata_q;

      // Read and write on the same edge: the read sees the old byte.
      always_ff @(posedge clk_i) begin
        if (re_i) begin
          rdata_q <= mem[addr_i];
        end
        if (we_i[gi]) begin
          mem[addr_i] <= wdata_i[gi*LANE_W +: LANE_W];
        end
      end

      assign rdata_o[gi*LANE_W +: LANE_W] = rdata_q;
    end
  endgenerate

endmodule : dmem_bytelane_ram

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the CPU data-memory request interface.  A held
//   read and/or byte-masked write request is captured in IDLE, delayed by
//   WAIT_STATES cycles, and completed with a one-cycle DataMem_Ack.  Read
//   data is registered and held until the next read completes.  Addresses
//   beyond the implemented RAM complete normally but raise Range_Err, write
//   nothing and read zero.
//
//   clock        system clock
//   reset        synchronous, active-high reset
//   Address      word address (byte address [31:2])
//   MWriteData   write data, lane-replicated by the requester
//   WriteEnable  per-byte write strobes
//   ReadEnable   read request
//   MReadData    read data
//   DataMem_Ack  one-cycle completion pulse
//   Range_Err    pulses with DataMem_Ack for an out-of-range access
// ---------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1   // 0 .. WAIT_STATES_MAX
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] Address,
  input  logic [31:0] MWriteData,
  input  logic [3:0]  WriteEnable,
  input  logic        ReadEnable,
  output logic [31:0] MReadData,
  output logic        DataMem_Ack,
  output logic        Range_Err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [29:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        we_q;
  logic              re_q;
  logic              err_q;
  logic              rd_zero_q;

  logic              req;
  logic              enter_ack;
  logic [29:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_we;
  logic              acc_re;
  logic              in_range;
  logic              ram_re;
  logic [3:0]        ram_we;
  logic [31:0]       ram_rdata;

  assign req = ReadEnable | (WriteEnable != 4'b0000);

  // With zero wait states the array is accessed on the capture edge itself,
  // so the access fields come straight from the bus while in IDLE.
  assign acc_addr  = (state_q == S_IDLE) ? Address     : addr_q;
  assign acc_wdata = (state_q == S_IDLE) ? MWriteData  : wdata_q;
  assign acc_we    = (state_q == S_IDLE) ? WriteEnable : we_q;
  assign acc_re    = (state_q == S_IDLE) ? ReadEnable  : re_q;

  assign in_range  = (acc_addr >> ADDR_WIDTH) == 30'd0;
  assign enter_ack = (state_d == S_ACK) && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= '0;
      re_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req) begin
        addr_q  <= Address;
        wdata_q <= MWriteData;
        we_q    <= WriteEnable;
        re_q    <= ReadEnable;
      end
      if (enter_ack) begin
        err_q <= !in_range;
        // Out-of-range reads present zero instead of the RAM register.
        if (acc_re) begin
          rd_zero_q <= !in_range;
        end
      end
    end
  end

  assign ram_re = enter_ack && acc_re && in_range;
  assign ram_we = acc_we & {4{enter_ack && in_range}};

  dmem_bytelane_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clock),
    .addr_i  (acc_addr[ADDR_WIDTH-1:0]),
    .re_i    (ram_re),
    .we_i    (ram_we),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  assign MReadData   = rd_zero_q ? 32'h0000_0000 : ram_rdata;
  assign DataMem_Ack = (state_q == S_ACK);
  assign Range_Err   = (state_q == S_ACK) && err_q;

endmodule : data_mem_responder
